fire3_squeeze_ofm_writer: RTL and testbench

Downstream stage of the fire3 squeeze layer. It captures the DSP_NO parallel 16-bit channel results each time the squeeze layer pulses its sample strobe, then serialises them into the single-port fire3 squeeze feature-map RAM, one word per cycle, at a channel-interleaved address. After the last pixel has been written it raises the RAM feedback pulse that the squeeze layer uses to deassert its finish flag.

---
 rtl/fire3_squeeze_ofm_writer.sv | 196 +++++++++++++++++++
 tb/tb_fire3_squeeze_ofm_writer.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire3_squeeze_ofm_writer.sv
// fire3_squeeze_ofm_writer
// Takes the DSP_NO channel results of one squeeze-layer pixel in a single
// strobe and writes them into the single-port squeeze feature-map RAM, one
// word per cycle. The RAM address is pix*DSP_NO + ch, so the channels of a
// pixel are stored contiguously. When the last word of the last pixel has
// been written, a one-cycle ram_feedback pulse is raised and the block parks
// in DONE until it is reset or restarted.
module fire3_squeeze_ofm_writer #(
    parameter int WOUT   = 64,
    parameter int DSP_NO = 16,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fire3_squeeze_sample,
    input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
    input  logic              restart,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic              ram_feedback,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int NPIX  = WOUT * WOUT;
    localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(DSP_NO - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DSP_NO);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CH_W-1:0]   ch_q;
    logic [PIX_W-1:0]  pix_q;
    logic [WIDTH-1:0]  shadow_q [0:DSP_NO-1];

    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [WIDTH-1:0]  ram_wdata_q;
    logic              ram_feedback_q;
    logic              busy_q;
    logic              done_q;
    logic              overflow_q;

    // Decoded conditions for the current cycle.
    logic              in_burst;
    logic              last_word;
    logic              last_pix;
    logic              accept;
    logic              drop;
    logic [CH_W-1:0]   ch_d;
    logic [PIX_W-1:0]  pix_start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] burst_addr;

    // Acceptance, drop and next-address decode.
    always_comb begin
        in_burst  = (state_q == ST_BURST);
        last_word = in_burst && (ch_q == CH_LAST);
        last_pix  = (pix_q == PIX_LAST);

        // A new sample is taken when idle, or in the final word of a burst
        // that is not the final pixel (back-to-back with no bubble).
        accept = fire3_squeeze_sample && !restart &&
                 ((state_q == ST_IDLE) || (last_word && !last_pix));

        // Only a sample landing mid-burst is an upstream fault; samples seen
        // in DONE or during the final word of the run are silently ignored.
        drop = fire3_squeeze_sample && !restart && in_burst && (ch_q != CH_LAST);

        // Next channel index inside a burst; never used past the last word.
        ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);

        // Pixel that a newly accepted sample lands on. In BURST the current
        // pixel is still pix_q, so a back-to-back sample takes the next one.
        pix_start = in_burst ? (pix_q + PIX_W'(1)) : pix_q;

        start_addr = ADDR_W'(pix_start) * STRIDE;
        burst_addr = ADDR_W'(pix_q) * STRIDE + ADDR_W'(ch_d);
    end

    // Shadow buffer: one register per channel, loaded on every accepted sample.
    generate
        for (genvar gi = 0; gi < DSP_NO; gi++) begin : g_shadow
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_q[gi] <= '0;
                end else if (accept) begin
                    shadow_q[gi] <= ofm[gi];
                end
            end
        end
    endgenerate

    // Control FSM with registered RAM-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            pix_q          <= '0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            ram_feedback_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else if (restart) begin
            // Restart wins over any sample in the same cycle and aborts a
            // burst in progress; the last address/data simply hold.
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            pix_q          <= '0;
            ram_we_q       <= 1'b0;
            ram_feedback_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            ram_feedback_q <= 1'b0;
            if (drop) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        // Word 0 comes straight from ofm; the rest from shadow.
                        state_q     <= ST_BURST;
                        ch_q        <= '0;
                        ram_we_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        ram_addr_q  <= start_addr;
                        ram_wdata_q <= ofm[0];
                    end
                end

                ST_BURST: begin
                    if (!last_word) begin
                        ch_q        <= ch_d;
                        ram_addr_q  <= burst_addr;
                        ram_wdata_q <= shadow_q[ch_d];
                    end else if (last_pix) begin
                        // Final word of the run is on the bus this cycle.
                        state_q        <= ST_DONE;
                        ch_q           <= '0;
                        ram_we_q       <= 1'b0;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                        ram_feedback_q <= 1'b1;
                    end else begin
                        pix_q <= pix_q + PIX_W'(1);
                        ch_q  <= '0;
                        if (accept) begin
                            ram_addr_q  <= start_addr;
                            ram_wdata_q <= ofm[0];
                        end else begin
                            state_q  <= ST_IDLE;
                            ram_we_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end
                end

                ST_DONE: begin
                    // Parked until rst or restart.
                end

                default: begin
                    state_q  <= ST_IDLE;
                    ram_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign ram_feedback = ram_feedback_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_fire3_squeeze_ofm_writer.sv
// Testbench for fire3_squeeze_ofm_writer (WOUT=4, DSP_NO=16).
// A reference model predicts the RAM write stream from sample times alone:
// a sample at cycle t is taken unless an earlier burst still has writes
// pending after t, and an accepted sample on pixel p writes word i at
// cycle t+1+i to address p*16+i.
module tb_fire3_squeeze_ofm_writer;

    localparam int WOUT   = 4;
    localparam int DSP_NO = 16;
    localparam int WIDTH  = 16;
    localparam int NPIX   = WOUT * WOUT;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample = 1'b0;
    logic              restart = 1'b0;
    logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_wdata;
    logic              ram_feedback;
    logic              busy;
    logic              done;
    logic              overflow;

    fire3_squeeze_ofm_writer #(
        .WOUT   (WOUT),
        .DSP_NO (DSP_NO),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fire3_squeeze_sample (sample),
        .ofm                  (ofm),
        .restart              (restart),
        .ram_we               (ram_we),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_feedback         (ram_feedback),
        .busy                 (busy),
        .done                 (done),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  fb_q[$];
    int  busy_cnt = 0;
    int  done_cyc = -1;

    int tests = 0;
    int fails = 0;

    // Observed stream, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                wr_t w;
                w.cyc  = cyc;
                w.addr = int'(ram_addr);
                w.data = int'(ram_wdata);
                got_q.push_back(w);
            end
            if (ram_feedback) fb_q.push_back(cyc);
            if (busy) busy_cnt++;
            if (done && done_cyc < 0) done_cyc = cyc;
        end
    end

    // Reference model state.
    int m_pix;
    int m_end;
    bit m_ovf;

    function automatic void model_reset();
        m_pix = 0;
        m_end = -1;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_sample(int t);
        if (t < m_end) begin
            m_ovf = 1'b1;
        end else if (m_pix < NPIX) begin
            for (int i = 0; i < DSP_NO; i++) begin
                wr_t w;
                w.cyc  = t + 1 + i;
                w.addr = m_pix * DSP_NO + i;
                w.data = int'(ofm[i]);
                exp_q.push_back(w);
            end
            m_end = t + DSP_NO;
            m_pix++;
        end
    endfunction

    function automatic void clear_mon();
        got_q.delete();
        exp_q.delete();
        fb_q.delete();
        busy_cnt = 0;
        done_cyc = -1;
    endfunction

    task automatic rand_ofm();
        for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'($urandom);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; strobes sample for exactly one cycle.
    task automatic drive_sample(output int t);
        sample = 1'b1;
        t = cyc;
        model_sample(t);
        @(posedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        model_reset();
        clear_mon();
    endtask

    task automatic test_reset();
        int nbad;
        for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
        rst = 1'b1;
        wait_cyc(3);
        tests++;
        if ({ram_we, ram_addr, ram_wdata, ram_feedback, busy, done, overflow} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got we=%b addr=%0h data=%0h fb=%b busy=%b done=%b ovf=%b, required all 0",
                     ram_we, ram_addr, ram_wdata, ram_feedback, busy, done, overflow);
        end
        rst = 1'b0;
        model_reset();
        clear_mon();
        wait_cyc(3);
        nbad = got_q.size();
        tests++;
        if (nbad != 0) begin
            fails++;
            $display("FAIL reset_idle_writes: got %0d writes, required 0", nbad);
        end
    endtask

    task automatic test_single();
        int t;
        int nbad = 0;
        for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(16'h0100 + i);
        drive_sample(t);
        wait_cyc(20);
        tests++;
        if (got_q.size() != exp_q.size()) begin
            nbad = 1;
            $display("FAIL single_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr != exp_q[i].addr ||
                    got_q[i].data != exp_q[i].data) begin
                    if (nbad == 0)
                        $display("FAIL single_word%0d: got cyc=%0d addr=%0d data=%0h, required cyc=%0d addr=%0d data=%0h",
                                 i, got_q[i].cyc, got_q[i].addr, got_q[i].data,
                                 exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                    nbad++;
                end
            end
        end
        if (nbad != 0) fails++;
        tests++;
        if (busy_cnt != DSP_NO) begin
            fails++;
            $display("FAIL single_busy: got %0d busy cycles, required %0d", busy_cnt, DSP_NO);
        end
        tests++;
        if (overflow !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL single_flags: got ovf=%b done=%b, required 0 0", overflow, done);
        end
        $display("[TB] single sample at cycle %0d: %0d writes", t, got_q.size());
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        int nbad = 0;
        do_restart();
        rand_ofm();
        drive_sample(t0);
        wait_cyc(DSP_NO - 1);
        rand_ofm();
        drive_sample(t1);
        wait_cyc(20);
        tests++;
        if (got_q.size() != 2 * DSP_NO || got_q.size() != exp_q.size()) begin
            nbad = 1;
            $display("FAIL b2b_count: got %0d writes, required %0d", got_q.size(), 2 * DSP_NO);
        end else begin
            foreach (exp_q[i]) begin
                if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr != exp_q[i].addr ||
                    got_q[i].data != exp_q[i].data) begin
                    if (nbad == 0)
                        $display("FAIL b2b_word%0d: got cyc=%0d addr=%0d data=%0h, required cyc=%0d addr=%0d data=%0h",
                                 i, got_q[i].cyc, got_q[i].addr, got_q[i].data,
                                 exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                    nbad++;
                end
            end
        end
        if (nbad != 0) fails++;
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL b2b_overflow: got %b, required 0", overflow);
        end
        $display("[TB] back-to-back samples at %0d and %0d: %0d writes", t0, t1, got_q.size());
    endtask

    task automatic test_overflow_drop();
        int t0, t1, t2;
        int nbad = 0;
        do_restart();
        rand_ofm();
        drive_sample(t0);
        wait_cyc(4);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL drop_ovf_early: got %b at T+5, required 0", overflow);
        end
        rand_ofm();
        drive_sample(t1);
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL drop_ovf_set: got %b at T+6, required 1", overflow);
        end
        wait_cyc(14);
        rand_ofm();
        drive_sample(t2);
        wait_cyc(20);
        tests++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 2 * DSP_NO) begin
            nbad = 1;
            $display("FAIL drop_count: got %0d writes, required %0d", got_q.size(), 2 * DSP_NO);
        end else begin
            foreach (exp_q[i]) begin
                if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr != exp_q[i].addr ||
                    got_q[i].data != exp_q[i].data) begin
                    if (nbad == 0)
                        $display("FAIL drop_word%0d: got cyc=%0d addr=%0d data=%0h, required cyc=%0d addr=%0d data=%0h",
                                 i, got_q[i].cyc, got_q[i].addr, got_q[i].data,
                                 exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                    nbad++;
                end
            end
        end
        if (nbad != 0) fails++;
        tests++;
        if (overflow !== m_ovf) begin
            fails++;
            $display("FAIL drop_ovf_sticky: got %b, required %b", overflow, m_ovf);
        end
        $display("[TB] overflow drop: samples at %0d, %0d (dropped), %0d", t0, t1, t2);
    endtask

    task automatic test_random_cadence();
        int t;
        int nbad = 0;
        do_restart();
        for (int k = 0; k < 12; k++) begin
            rand_ofm();
            drive_sample(t);
            wait_cyc($urandom_range(1, 22));
        end
        wait_cyc(20);
        tests++;
        if (got_q.size() != exp_q.size()) begin
            nbad = 1;
            $display("FAIL rand_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr != exp_q[i].addr ||
                    got_q[i].data != exp_q[i].data) begin
                    if (nbad == 0)
                        $display("FAIL rand_word%0d: got cyc=%0d addr=%0d data=%0h, required cyc=%0d addr=%0d data=%0h",
                                 i, got_q[i].cyc, got_q[i].addr, got_q[i].data,
                                 exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                    nbad++;
                end
            end
        end
        if (nbad != 0) fails++;
        tests++;
        if (overflow !== m_ovf) begin
            fails++;
            $display("FAIL rand_overflow: got %b, required %b", overflow, m_ovf);
        end
        tests++;
        if (busy_cnt != exp_q.size()) begin
            fails++;
            $display("FAIL rand_busy: got %0d busy cycles, required %0d", busy_cnt, exp_q.size());
        end
        $display("[TB] random cadence: %0d pixels accepted, overflow=%b", m_pix, overflow);
    endtask

    task automatic test_reset_mid_burst();
        int t;
        int nbad = 0;
        do_restart();
        rand_ofm();
        drive_sample(t);
        wait_cyc(7);
        tests++;
        if (ram_we !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_we_before: got %b at T+8, required 1", ram_we);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({ram_we, ram_addr, ram_wdata, ram_feedback, busy, done, overflow} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got we=%b addr=%0h data=%0h busy=%b, required all 0",
                     ram_we, ram_addr, ram_wdata, busy);
        end
        tests++;
        if (got_q.size() != 7) begin
            nbad = 1;
            $display("FAIL rstmid_prefix_count: got %0d writes, required 7", got_q.size());
        end else begin
            foreach (got_q[i]) begin
                if (got_q[i].addr != exp_q[i].addr || got_q[i].data != exp_q[i].data) begin
                    if (nbad == 0)
                        $display("FAIL rstmid_prefix%0d: got addr=%0d data=%0h, required addr=%0d data=%0h",
                                 i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
                    nbad++;
                end
            end
        end
        if (nbad != 0) fails++;
        wait_cyc(2);
        rst = 1'b0;
        model_reset();
        clear_mon();
        wait_cyc(2);
        rand_ofm();
        drive_sample(t);
        wait_cyc(20);
        nbad = 0;
        tests++;
        if (got_q.size() != exp_q.size() || exp_q.size() != DSP_NO) begin
            nbad = 1;
            $display("FAIL rstmid_after_count: got %0d writes, required %0d", got_q.size(), DSP_NO);
        end else begin
            foreach (exp_q[i]) begin
                if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr != exp_q[i].addr ||
                    got_q[i].data != exp_q[i].data) begin
                    if (nbad == 0)
                        $display("FAIL rstmid_after%0d: got addr=%0d data=%0h, required addr=%0d data=%0h",
                                 i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
                    nbad++;
                end
            end
        end
        if (nbad != 0) fails++;
        $display("[TB] reset mid-burst, next sample at %0d", t);
    endtask

    task automatic test_full_run();
        int t;
        int fin;
        int nbad = 0;
        int seen [0:NPIX*DSP_NO-1];
        do_restart();
        for (int k = 0; k < NPIX; k++) begin
            rand_ofm();
            drive_sample(t);
            wait_cyc(128);
        end
        // 17th sample lands in DONE and must be ignored.
        rand_ofm();
        drive_sample(t);
        wait_cyc(20);
        tests++;
        if (got_q.size() != exp_q.size() || exp_q.size() != NPIX * DSP_NO) begin
            nbad = 1;
            $display("FAIL full_count: got %0d writes, required %0d", got_q.size(), NPIX * DSP_NO);
        end else begin
            foreach (exp_q[i]) begin
                if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr != exp_q[i].addr ||
                    got_q[i].data != exp_q[i].data) begin
                    if (nbad == 0)
                        $display("FAIL full_word%0d: got cyc=%0d addr=%0d data=%0h, required cyc=%0d addr=%0d data=%0h",
                                 i, got_q[i].cyc, got_q[i].addr, got_q[i].data,
                                 exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                    nbad++;
                end
            end
        end
        if (nbad != 0) fails++;
        // Every address 0..255 written exactly once.
        foreach (seen[a]) seen[a] = 0;
        foreach (got_q[i]) if (got_q[i].addr < NPIX * DSP_NO) seen[got_q[i].addr]++;
        nbad = 0;
        foreach (seen[a]) if (seen[a] != 1) nbad++;
        tests++;
        if (nbad != 0) begin
            fails++;
            $display("FAIL full_coverage: got %0d addresses not written exactly once, required 0", nbad);
        end
        fin = (exp_q.size() > 0) ? exp_q[exp_q.size()-1].cyc : 0;
        tests++;
        if (fb_q.size() != 1 || fb_q[0] != fin + 1) begin
            fails++;
            $display("FAIL full_feedback: got %0d pulses (first at %0d), required 1 at %0d",
                     fb_q.size(), (fb_q.size() > 0) ? fb_q[0] : -1, fin + 1);
        end
        tests++;
        if (done_cyc != fin + 1 || done !== 1'b1) begin
            fails++;
            $display("FAIL full_done: got rise at %0d now %b, required rise at %0d now 1",
                     done_cyc, done, fin + 1);
        end
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_overflow: got %b, required 0", overflow);
        end
        $display("[TB] full run: %0d writes, last at cycle %0d", got_q.size(), fin);
    endtask

    task automatic test_restart_with_sample();
        int t;
        int nbad = 0;
        rand_ofm();
        restart = 1'b1;
        sample  = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        sample  = 1'b0;
        tests++;
        if (done !== 1'b0 || overflow !== 1'b0 || ram_we !== 1'b0) begin
            fails++;
            $display("FAIL restart_flags: got done=%b ovf=%b we=%b, required 0 0 0", done, overflow, ram_we);
        end
        model_reset();
        clear_mon();
        wait_cyc(3);
        tests++;
        if (got_q.size() != 0) begin
            fails++;
            $display("FAIL restart_no_write: got %0d writes, required 0", got_q.size());
        end
        rand_ofm();
        drive_sample(t);
        wait_cyc(20);
        tests++;
        if (got_q.size() != exp_q.size() || exp_q.size() != DSP_NO) begin
            nbad = 1;
            $display("FAIL restart_next_count: got %0d writes, required %0d", got_q.size(), DSP_NO);
        end else begin
            foreach (exp_q[i]) begin
                if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr != exp_q[i].addr ||
                    got_q[i].data != exp_q[i].data) begin
                    if (nbad == 0)
                        $display("FAIL restart_next%0d: got addr=%0d data=%0h, required addr=%0d data=%0h",
                                 i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
                    nbad++;
                end
            end
        end
        if (nbad != 0) fails++;
        $display("[TB] restart with sample, next sample at %0d", t);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow_drop();
        test_random_cadence();
        test_reset_mid_burst();
        test_full_run();
        test_restart_with_sample();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
